// File: rtl/approx_rca_pipe.sv
// Pipelined ripple-carry adder with approximate low-order cells
// and on-line error statistics against a shadow exact sum.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   in_valid/in_ready operand beat handshake
//   a, b, cin, mode   operands, carry-in, 1 = approximate low bits
//   out_valid/out_ready result beat handshake
//   sum, cout         result of the selected adder
//   err_flag          result differs from the exact {cout,sum}
//   clr_stats         synchronous clear of the statistics
//   err_count         saturating count of delivered mismatches
//   err_max           largest delivered |exact - result|
module approx_rca_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err_flag,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   err_max
);

    // Combinational adders
    logic [WIDTH-1:0] rca_s;
    logic             rca_c;
    logic [WIDTH:0]   exact_c;

    always_comb begin
        logic carry;
        rca_s = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            rca_s[i] = a[i] ^ b[i] ^ carry;
            // Approximate cell drops the propagate term of the carry.
            if (mode && (i < APPROX_BITS)) begin
                carry = a[i] & b[i];
            end else begin
                carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
            end
        end
        rca_c = carry;
    end

    assign exact_c = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Pipeline registers
    logic [STAGES-1:0] pv;
    logic [WIDTH-1:0]  ps [STAGES];
    logic              pc [STAGES];
    logic [WIDTH:0]    pe [STAGES];
    logic              pm [STAGES];

    logic stall;
    logic deliver;

    assign out_valid = pv[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign deliver   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ps[k] <= '0;
                pc[k] <= 1'b0;
                pe[k] <= '0;
                pm[k] <= 1'b0;
            end
        end else if (!stall) begin
            // Not stalled means in_ready is high, so in_valid is acceptance.
            pv[0] <= in_valid;
            if (in_valid) begin
                ps[0] <= rca_s;
                pc[0] <= rca_c;
                pe[0] <= exact_c;
                pm[0] <= mode;
            end
            // Bubbles shift along with valid beats.
            for (int k = 1; k < STAGES; k++) begin
                pv[k] <= pv[k-1];
                ps[k] <= ps[k-1];
                pc[k] <= pc[k-1];
                pe[k] <= pe[k-1];
                pm[k] <= pm[k-1];
            end
        end
    end

    // Output view of the last stage
    logic [WIDTH:0] res;
    logic [WIDTH:0] mag;

    assign sum      = ps[STAGES-1];
    assign cout     = pc[STAGES-1];
    assign res      = {pc[STAGES-1], ps[STAGES-1]};
    // Exact beats cannot mismatch, so mode gates the comparison.
    assign err_flag = pm[STAGES-1] & (res != pe[STAGES-1]);
    // Dropped carries only remove value, so this never underflows.
    assign mag      = pe[STAGES-1] - res;

    // Statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            err_max   <= '0;
        end else if (clr_stats) begin
            err_count <= '0;
            err_max   <= '0;
        end else if (deliver) begin
            if (err_flag && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
            if (mag > err_max) begin
                err_max <= mag;
            end
        end
    end

endmodule
